// File: rtl/gray_pkg.sv
// gray_pkg
//   Shared constants and helpers for the pipelined Gray/binary converter
//   (gray_bin_pipe_conv and its gray_conv_stage sub-module).
//
//   MODE_G2B / MODE_B2G : per-beat direction select carried with each word.
//   stage_count(n, chunk): pipeline depth, ceil(n / chunk).
//   popcount(x)          : number of set bits. Used by the optional step check.
//                          Operand is POPCOUNT_W bits wide; narrower words are
//                          zero-extended by the caller.

package gray_pkg;

    localparam logic MODE_G2B = 1'b0;
    localparam logic MODE_B2G = 1'b1;

    // Widest word the step checker can compare.
    localparam int unsigned POPCOUNT_W = 64;

    function automatic int unsigned stage_count(input int unsigned n, input int unsigned chunk);
        return (n + chunk - 1) / chunk;
    endfunction

    function automatic int unsigned popcount(input logic [POPCOUNT_W-1:0] x);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < int'(POPCOUNT_W); i++) begin
            cnt = cnt + {31'd0, x[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/gray_conv_stage.sv
// gray_conv_stage
//   One register stage of the Gray/binary pipeline. Holds a valid bit, the
//   word in progress, its mode and the binary bit carried out of this stage's
//   chunk.
//
//   For G2B beats the stage resolves bits HI down to LO. It starts from
//   up_carry, which is bin[HI+1] from the previous stage, or 0 for the first
//   stage. Bits outside [HI:LO] pass through unchanged.
//   For B2G beats the first stage (FIRST = 1) computes b ^ (b >> 1). Later
//   stages pass the word through, so both modes have the same latency.
//
//   Ports
//     clk, rst    : clock, synchronous active-high reset
//     up_valid    : beat offered by the previous stage or by the block input
//     up_data     : word offered (partially resolved for G2B)
//     up_mode     : MODE_G2B / MODE_B2G of the offered beat
//     up_carry    : bin[HI+1] for G2B beats
//     up_ready    : this stage loads this cycle (empty or draining)
//     down_ready  : the next stage, or the block output, takes this stage's beat
//     valid, data, mode, carry : registered stage contents

module gray_conv_stage
    import gray_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned HI    = 7,
    parameter int unsigned LO    = 4,
    parameter bit          FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         up_valid,
    input  logic [N-1:0] up_data,
    input  logic         up_mode,
    input  logic         up_carry,
    output logic         up_ready,
    input  logic         down_ready,
    output logic         valid,
    output logic [N-1:0] data,
    output logic         mode,
    output logic         carry
);

    logic [N-1:0] res;
    logic         chain;

    // Loading whenever the slot is empty or drains this cycle collapses bubbles.
    assign up_ready = !valid | down_ready;

    always_comb begin
        res   = up_data;
        chain = up_carry;
        if (up_mode == MODE_G2B) begin
            // MSB-first XOR chain over this stage's chunk only.
            for (int i = int'(HI); i >= int'(LO); i--) begin
                chain  = chain ^ up_data[i];
                res[i] = chain;
            end
        end else if (FIRST) begin
            res = up_data ^ (up_data >> 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            mode  <= 1'b0;
            carry <= 1'b0;
        end else if (up_ready) begin
            valid <= up_valid;
            if (up_valid) begin
                data  <= res;
                mode  <= up_mode;
                carry <= chain;
            end
        end
    end

endmodule

// File: rtl/gray_bin_pipe_conv.sv
// gray_bin_pipe_conv
//   Pipelined, bidirectional Gray/binary converter with valid/ready on both
//   sides. The G2B XOR chain is split into STAGES = ceil(N/CHUNK) registered
//   chunks. B2G is done in the first stage and then carried along, so each
//   beat takes exactly STAGES cycles when nothing stalls. Mode travels with
//   every beat, so mixed streams need no bubbles.
//
//   Parameters
//     N      : word width (>= 2)
//     CHUNK  : bits resolved per stage (1 .. N)
//
//   Ports
//     clk, rst            : clock, synchronous active-high reset
//     in_valid / in_ready : input handshake. in_ready depends combinationally
//                           on out_ready through the stage chain.
//     in_data, in_mode    : word and direction (0 = G2B, 1 = B2G)
//     out_valid/out_ready : output handshake. Outputs hold while stalled.
//     out_data, out_mode  : converted word and its direction
//     step_err            : only when GRAY_STEP_CHECK_EN is defined. This is a
//                           one-cycle registered pulse after a G2B input whose
//                           word is not exactly one bit away from the previous
//                           G2B input. The first G2B beat after reset never
//                           flags. The check compares at most POPCOUNT_W bits.
//
//   Optional feature macro: GRAY_STEP_CHECK_EN

module gray_bin_pipe_conv
    import gray_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned CHUNK = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic         in_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_mode
`ifdef GRAY_STEP_CHECK_EN
    ,
    output logic         step_err
`endif
);

    localparam int unsigned STAGES = stage_count(N, CHUNK);

    // Per-stage sources (what stage k would load) and registered contents.
    logic         src_valid [STAGES];
    logic [N-1:0] src_data  [STAGES];
    logic         src_mode  [STAGES];
    logic         src_carry [STAGES];
    logic         dn_ready  [STAGES];

    logic         st_valid  [STAGES];
    logic [N-1:0] st_data   [STAGES];
    logic         st_mode   [STAGES];
    logic         st_carry  [STAGES];
    logic         st_ready  [STAGES];

    for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
        localparam int unsigned HI = N - 1 - k * CHUNK;
        // The last stage takes whatever remains when CHUNK does not divide N.
        localparam int unsigned LO = (N > (k + 1) * CHUNK) ? N - (k + 1) * CHUNK : 0;

        if (k == 0) begin : g_src_in
            assign src_valid[k] = in_valid;
            assign src_data[k]  = in_data;
            assign src_mode[k]  = in_mode;
            assign src_carry[k] = 1'b0;  // bin[N-1] = g[N-1] ^ 0
        end else begin : g_src_prev
            assign src_valid[k] = st_valid[k-1];
            assign src_data[k]  = st_data[k-1];
            assign src_mode[k]  = st_mode[k-1];
            assign src_carry[k] = st_carry[k-1];
        end

        if (k == int'(STAGES) - 1) begin : g_dn_out
            assign dn_ready[k] = out_ready;
        end else begin : g_dn_next
            assign dn_ready[k] = st_ready[k+1];
        end

        gray_conv_stage #(
            .N     (N),
            .HI    (HI),
            .LO    (LO),
            .FIRST (k == 0)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .up_valid   (src_valid[k]),
            .up_data    (src_data[k]),
            .up_mode    (src_mode[k]),
            .up_carry   (src_carry[k]),
            .up_ready   (st_ready[k]),
            .down_ready (dn_ready[k]),
            .valid      (st_valid[k]),
            .data       (st_data[k]),
            .mode       (st_mode[k]),
            .carry      (st_carry[k])
        );
    end

    assign in_ready  = st_ready[0];
    assign out_valid = st_valid[STAGES-1];
    assign out_data  = st_data[STAGES-1];
    assign out_mode  = st_mode[STAGES-1];

`ifdef GRAY_STEP_CHECK_EN
    logic [N-1:0] last_g2b;
    logic         seen;
    logic         g2b_fire;

    assign g2b_fire = in_valid & in_ready & (in_mode == MODE_G2B);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_g2b <= '0;
            seen     <= 1'b0;
            step_err <= 1'b0;
        end else begin
            // A repeated word (distance 0) is flagged as well as multi-bit jumps.
            step_err <= g2b_fire & seen &
                        (popcount(POPCOUNT_W'(in_data ^ last_g2b)) != 1);
            if (g2b_fire) begin
                last_g2b <= in_data;
                seen     <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_gray_bin_pipe_conv.sv
module tb_gray_bin_pipe_conv;
    import gray_pkg::*;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_mode;
`ifdef GRAY_STEP_CHECK_EN
    logic       step_err;
`endif

    gray_bin_pipe_conv #(
        .N     (8),
        .CHUNK (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_mode  (out_mode)
`ifdef GRAY_STEP_CHECK_EN
        ,
        .step_err  (step_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;
    int out_count;

    typedef struct packed {
        logic [7:0] data;
        logic       mode;
    } beat_t;

    beat_t      sb_q[$];
    logic [7:0] cap_q[$];
    logic [7:0] stim_q[$];

    typedef struct {
        logic [7:0] din;
        logic       mode;
        logic [7:0] exp;
    } vec_t;

    vec_t vt [9];

    // Reference models: G2B as XOR of all right shifts, B2G by definition.
    function automatic logic [7:0] m_g2b(input logic [7:0] g);
        logic [7:0] b;
        b = 8'h00;
        for (int s = 0; s < 8; s++) b = b ^ (g >> s);
        return b;
    endfunction

    function automatic logic [7:0] m_b2g(input logic [7:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: samples handshakes mid-cycle, before the edge that commits them.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                out_count++;
                cap_q.push_back(out_data);
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected: got data %0h mode %0d with no beat pending",
                             out_data, out_mode);
                end else begin
                    beat_t e;
                    e = sb_q.pop_front();
                    check("sb_data", {24'd0, out_data}, {24'd0, e.data});
                    check("sb_mode", {31'd0, out_mode}, {31'd0, e.mode});
                end
            end
            if (in_valid && in_ready) begin
                sb_q.push_back('{data: (in_mode ? m_b2g(in_data) : m_g2b(in_data)),
                                 mode: in_mode});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    // Offer one beat and hold it until accepted. Returns at the accepting edge + 1.
    task automatic send_beat(input logic [7:0] d, input logic m);
        int   cyc;
        logic rdy;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        cyc = 0;
        do begin
            @(negedge clk);
            rdy = in_ready;
            cyc++;
        end while (!rdy && cyc < 50);
        check("accept_in_ready", {31'd0, rdy}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic run_stream(input logic mode, input bit rnd);
        int idx;
        int cyc;
        idx = 0;
        cyc = 0;
        while ((idx < stim_q.size() || sb_q.size() != 0) && cyc < 4000) begin
            @(posedge clk); #1;
            in_valid  = (idx < stim_q.size());
            in_data   = (idx < stim_q.size()) ? stim_q[idx] : 8'h00;
            in_mode   = mode;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            cyc++;
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("stream_sent", idx, stim_q.size());
        check("stream_drained", sb_q.size(), 0);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        int         lat;
        int         sent;
        int         base;
        int         seen_valid;
        logic [7:0] bp [6];

        checks    = 0;
        failures  = 0;
        out_count = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_mode   = 1'b0;
        out_ready = 1'b1;

        vt[0] = '{8'h80, 1'b0, 8'hFF};
        vt[1] = '{8'hC5, 1'b0, 8'h86};
        vt[2] = '{8'h86, 1'b1, 8'hC5};
        vt[3] = '{8'h00, 1'b0, 8'h00};
        vt[4] = '{8'hFF, 1'b1, 8'h80};
        vt[5] = '{8'hFF, 1'b0, 8'hAA};
        vt[6] = '{8'h01, 1'b1, 8'h01};
        vt[7] = '{8'h7F, 1'b1, 8'h40};
        vt[8] = '{8'h40, 1'b0, 8'h7F};

        bp[0] = 8'h10; bp[1] = 8'h3C; bp[2] = 8'hF0;
        bp[3] = 8'h55; bp[4] = 8'hAA; bp[5] = 8'h81;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        check("rst_out_mode", {31'd0, out_mode}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef GRAY_STEP_CHECK_EN
        check("rst_step_err", {31'd0, step_err}, 32'd0);
`endif

        // Single beats against hand-derived vectors, with exact latency.
        for (int i = 0; i < 9; i++) begin
            send_beat(vt[i].din, vt[i].mode);
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
            end while (!out_valid && lat < 10);
            check("vec_latency", lat, 2);
            check("vec_data", {24'd0, out_data}, {24'd0, vt[i].exp});
            check("vec_mode", {31'd0, out_mode}, {31'd0, vt[i].mode});
        end
        @(posedge clk);

        // Back-to-back beats with alternating modes.
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 8'hC5; in_mode = 1'b0;
        @(negedge clk);
        check("b2b_ready0", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_data = 8'h86; in_mode = 1'b1;
        @(negedge clk);
        check("b2b_ready1", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 10);
        check("b2b_first_valid", {31'd0, out_valid}, 32'd1);
        check("b2b_first_data", {24'd0, out_data}, 32'h86);
        check("b2b_first_mode", {31'd0, out_mode}, 32'd0);
        @(negedge clk);
        check("b2b_second_valid", {31'd0, out_valid}, 32'd1);
        check("b2b_second_data", {24'd0, out_data}, 32'hC5);
        check("b2b_second_mode", {31'd0, out_mode}, 32'd1);
        repeat (2) @(posedge clk);

        // Back-pressure: output stalled for the first 5 cycles.
        sent = 0;
        base = out_count;
        for (int c = 0; c < 60 && (sent < 6 || sb_q.size() != 0); c++) begin
            @(posedge clk); #1;
            out_ready = (c >= 5);
            in_valid  = (sent < 6);
            in_data   = bp[(sent < 6) ? sent : 0];
            in_mode   = 1'b0;
            @(negedge clk);
            if (c == 4) begin
                check("bp_accepted", sent, 2);
                check("bp_in_ready", {31'd0, in_ready}, 32'd0);
                check("bp_out_held", {31'd0, out_valid}, 32'd1);
                check("bp_out_data", {24'd0, out_data}, {24'd0, m_g2b(bp[0])});
            end
            if (in_valid && in_ready) sent++;
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("bp_out_count", out_count - base, 6);

        // Reset with two beats in flight; neither may ever come out.
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1; in_data = 8'h11; in_mode = 1'b0;
        @(posedge clk); #1;
        in_data = 8'h22;
        @(posedge clk); #1;
        rst     = 1'b1;
        in_data = 8'h33;
        @(posedge clk); #1;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("rstmid_out_valid", {31'd0, out_valid}, 32'd0);
        check("rstmid_out_data", {24'd0, out_data}, 32'd0);
        check("rstmid_in_ready", {31'd0, in_ready}, 32'd1);
        seen_valid = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen_valid++;
        end
        check("rstmid_no_output", seen_valid, 0);

        // Exhaustive round trip: B2G all words, then G2B the DUT's own results.
        stim_q.delete();
        for (int w = 0; w < 256; w++) stim_q.push_back(8'(w));
        cap_q.delete();
        run_stream(1'b1, 1'b1);
        check("rt_b2g_count", cap_q.size(), 256);
        stim_q = cap_q;
        cap_q.delete();
        run_stream(1'b0, 1'b1);
        check("rt_g2b_count", cap_q.size(), 256);
        for (int w = 0; w < cap_q.size(); w++) begin
            check("roundtrip", {24'd0, cap_q[w]}, w);
        end

`ifdef GRAY_STEP_CHECK_EN
        begin
            logic [7:0] sd [6];
            logic       sm [6];
            logic       se [6];
            sd[0] = 8'h00; sm[0] = 1'b0; se[0] = 1'b0;
            sd[1] = 8'h01; sm[1] = 1'b0; se[1] = 1'b0;
            sd[2] = 8'h03; sm[2] = 1'b0; se[2] = 1'b0;
            sd[3] = 8'hFF; sm[3] = 1'b1; se[3] = 1'b0;
            sd[4] = 8'h00; sm[4] = 1'b0; se[4] = 1'b1;
            sd[5] = 8'h00; sm[5] = 1'b0; se[5] = 1'b1;
            pulse_reset();
            for (int i = 0; i < 6; i++) begin
                send_beat(sd[i], sm[i]);
                @(negedge clk);
                check("step_err_pulse", {31'd0, step_err}, {31'd0, se[i]});
                @(negedge clk);
                check("step_err_clear", {31'd0, step_err}, 32'd0);
            end
        end
`endif

        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
